// File: rtl/readout_sequencer.sv
// -----------------------------------------------------------------------------
// readout_sequencer
//
// Scan controller for the multi-channel impulse counter bank. A rising edge on
// rtc starts one readout frame. For every channel (0 .. NUM_CH-1) the sequencer
// spends one LOAD cycle (sl=1, cnt_clr=1) capturing the channel count and its
// overflow flag, then shifts the captured count out MSB-first on serial_out.
//
// Optional build macro: PARITY_EN
//   defined   : one extra shift cycle per channel carrying even parity
//               (XOR of the captured CNT_W data bits).
//   undefined : data bits only.
//
// Ports
//   clk         in   1       system clock, rising edge
//   reset       in   1       synchronous active-high reset
//   rtc         in   1       frame request level; rising edge starts a frame
//   ch_count    in   CNT_W   count of the channel selected by addr
//   ch_ovf      in   1       overflow flag of the channel selected by addr
//   addr        out  ADDR_W  channel select to the counter bank
//   sl          out  1       1 = load/snapshot cycle, 0 = shift
//   cnt_clr     out  1       clear pulse for the selected channel (with sl)
//   serial_out  out  1       serial data, MSB first, channel 0 first
//   ovf_ch_out  out  1       overflow flag of the channel being shifted
//   ovf_global  out  1       OR of ch_ovf over channels loaded this frame
//   ovf_rtc     out  1       sticky: frame request arrived while busy
//   busy        out  1       sequencer not idle
//   done        out  1       one-cycle pulse on return to idle after a frame
// -----------------------------------------------------------------------------
module readout_sequencer #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rtc,
    input  logic [CNT_W-1:0]  ch_count,
    input  logic              ch_ovf,
    output logic [ADDR_W-1:0] addr,
    output logic              sl,
    output logic              cnt_clr,
    output logic              serial_out,
    output logic              ovf_ch_out,
    output logic              ovf_global,
    output logic              ovf_rtc,
    output logic              busy,
    output logic              done
);

`ifdef PARITY_EN
    localparam int BITS = CNT_W + 1;
`else
    localparam int BITS = CNT_W;
`endif
    localparam int BC_W = $clog2(BITS + 1);
    localparam logic [BC_W-1:0]   LAST_BIT = BC_W'(BITS - 1);
    localparam logic [ADDR_W-1:0] LAST_CH  = ADDR_W'(NUM_CH - 1);
`ifdef PARITY_EN
    // Bit counter value of the last data bit; the cycle after it carries parity.
    localparam logic [BC_W-1:0]   LAST_DATA = BC_W'(CNT_W - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    shreg_q, shreg_d;
    logic [BC_W-1:0]     bitcnt_q, bitcnt_d;
    logic                serial_q, serial_d;
    logic                ovf_ch_q, ovf_ch_d;
    logic                ovf_glob_q, ovf_glob_d;
    logic                ovf_rtc_q, ovf_rtc_d;
    logic                done_q, done_d;
    logic                rtc_q;
    logic                rtc_edge;
`ifdef PARITY_EN
    logic                par_q, par_d;
`endif

    assign rtc_edge = rtc & ~rtc_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        serial_d   = 1'b0;
        ovf_ch_d   = ovf_ch_q;
        ovf_glob_d = ovf_glob_q;
        done_d     = 1'b0;
        // Any request that cannot start a frame is dropped and remembered.
        ovf_rtc_d  = ovf_rtc_q | (rtc_edge & (state_q != S_IDLE));
`ifdef PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                addr_d = '0;
                if (rtc_edge) begin
                    state_d    = S_LOAD;
                    ovf_glob_d = 1'b0;
                end
            end
            S_LOAD: begin
                shreg_d    = ch_count;
                // serial_out is registered: preload the first data bit so it
                // appears in the first SHIFT cycle.
                serial_d   = ch_count[CNT_W-1];
                ovf_ch_d   = ch_ovf;
                ovf_glob_d = ovf_glob_q | ch_ovf;
                bitcnt_d   = '0;
`ifdef PARITY_EN
                par_d      = ^ch_count;
`endif
                state_d    = S_SHIFT;
            end
            S_SHIFT: begin
                shreg_d  = shreg_q << 1;
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == LAST_BIT) begin
                    if (addr_q == LAST_CH) begin
                        state_d = S_IDLE;
                        addr_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                        addr_d  = addr_q + 1'b1;
                    end
                end else begin
                    serial_d = shreg_d[CNT_W-1];
`ifdef PARITY_EN
                    if (bitcnt_q == LAST_DATA) begin
                        serial_d = par_q;
                    end
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // rtc is tracked even during reset so a level held high across reset
        // release is not mistaken for a new request.
        rtc_q <= rtc;
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            serial_q   <= 1'b0;
            ovf_ch_q   <= 1'b0;
            ovf_glob_q <= 1'b0;
            ovf_rtc_q  <= 1'b0;
            done_q     <= 1'b0;
`ifdef PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            serial_q   <= serial_d;
            ovf_ch_q   <= ovf_ch_d;
            ovf_glob_q <= ovf_glob_d;
            ovf_rtc_q  <= ovf_rtc_d;
            done_q     <= done_d;
`ifdef PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign addr       = addr_q;
    assign sl         = (state_q == S_LOAD);
    assign cnt_clr    = (state_q == S_LOAD);
    assign serial_out = serial_q;
    assign ovf_ch_out = ovf_ch_q;
    assign ovf_global = ovf_glob_q;
    assign ovf_rtc    = ovf_rtc_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;

endmodule
